// File: rtl/imem_access_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the instruction-memory access arbiter:
//   arb_state_e      : arbiter phase (BOOT while the image is loaded, RUN after)
//   IMEM_DEPTH_BYTES : byte depth of the default-sized instruction memory
//   addr_legal()     : word-aligned and inside a 2**awidth byte memory
// ---------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  localparam int unsigned IMEM_AWIDTH      = 10;
  localparam int unsigned IMEM_DEPTH_BYTES = 2 ** IMEM_AWIDTH;

  // Legal means the low two bits are clear and no bit at or above awidth is set.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned awidth);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << awidth) - 32'd1);
    return (addr[1:0] == 2'b00) && ((addr & hi_mask) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_access_arbiter_starve_ctr.sv
// ---------------------------------------------------------------------------
// imem_starve_ctr
// Saturating count of consecutive cycles the loader has been denied.
// Ports:
//   clk, rst : clock / synchronous active-high reset
//   inc      : loader requested and was not granted this cycle
//   clr      : loader granted or not requesting (wins over inc)
//   sat      : count has reached LIMIT
// ---------------------------------------------------------------------------
module imem_starve_ctr #(
  parameter int unsigned LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign sat = (cnt_q == CW'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_access_arbiter.sv
// ---------------------------------------------------------------------------
// imem_access_arbiter
// Shares the single port of instruction_memory between the core fetch unit
// and the program loader. BOOT: loader owns the port, core held. RUN (entered
// on l_done): fetch first, loader fills idle cycles, a starvation counter
// forces a loader slot after STARVE_LIMIT consecutive denials.
// Ports:
//   clk, rst                 : clock / synchronous active-high reset
//   f_req, f_addr            : fetch read request and byte address
//   f_gnt                    : fetch accepted this cycle (combinational)
//   f_rvalid, f_rdata, f_err : read result one cycle after f_gnt
//   l_req, l_addr, l_wdata   : loader write request
//   l_gnt                    : loader write accepted this cycle (combinational)
//   l_done                   : image complete, BOOT -> RUN
//   mem_addr, mem_data_in,
//   mem_WE, mem_data_out     : instruction_memory port (registered read data)
//   cpu_hold                 : high while in BOOT
//   load_err                 : sticky, a loader write was dropped
// ---------------------------------------------------------------------------
module imem_access_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned AWIDTH       = 10,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DWIDTH-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [DWIDTH-1:0] l_wdata,
  output logic              l_gnt,
  input  logic              l_done,
  output logic [31:0]       mem_addr,
  output logic [DWIDTH-1:0] mem_data_in,
  output logic              mem_WE,
  input  logic [DWIDTH-1:0] mem_data_out,
  output logic              cpu_hold,
  output logic              load_err
);

  arb_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_err_q, rd_err_d;
  logic              load_err_q, load_err_d;

  logic f_legal, l_legal;
  logic f_gnt_c, l_gnt_c, we_c;
  logic starve_inc, starve_clr, starve_sat;

  imem_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (starve_sat)
  );

  always_comb begin
    f_legal    = addr_legal(f_addr, AWIDTH);
    l_legal    = addr_legal(l_addr, AWIDTH);
    f_gnt_c    = 1'b0;
    l_gnt_c    = 1'b0;
    we_c       = 1'b0;
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_vld_d   = 1'b0;
    rd_err_d   = 1'b0;
    load_err_d = load_err_q;

    if (rst) begin
      // Outputs go to reset values during the reset cycle itself.
      state_d    = BOOT;
      addr_d     = '0;
      wdata_d    = '0;
      load_err_d = 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          l_gnt_c = l_req;
          if (l_done) state_d = RUN;
        end
        RUN: begin
          if (l_req && starve_sat) begin
            l_gnt_c = 1'b1;
          end else if (f_req) begin
            f_gnt_c = 1'b1;
          end else if (l_req) begin
            l_gnt_c = 1'b1;
          end
        end
        default: state_d = BOOT;
      endcase

      // Illegal requests are still granted; they just never touch memory.
      if (l_gnt_c) begin
        if (l_legal) begin
          we_c    = 1'b1;
          addr_d  = l_addr;
          wdata_d = l_wdata;
        end else begin
          load_err_d = 1'b1;
        end
      end

      if (f_gnt_c) begin
        rd_vld_d = 1'b1;
        rd_err_d = !f_legal;
        if (f_legal) addr_d = f_addr;
      end
    end
  end

  assign starve_inc = (state_q == RUN) && l_req && !l_gnt_c && !rst;
  assign starve_clr = l_gnt_c || !l_req || rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      rd_vld_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      load_err_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_vld_q   <= rd_vld_d;
      rd_err_q   <= rd_err_d;
      load_err_q <= load_err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Memory port is driven straight from the grant mux; idle cycles replay
  // the held address/data with WE low.
  assign mem_addr    = addr_d;
  assign mem_data_in = wdata_d;
  assign mem_WE      = we_c;
  assign f_gnt       = f_gnt_c;
  assign l_gnt       = l_gnt_c;

  // Read data returns the cycle after the grant, matching the memory's
  // registered output; an in-flight read is suppressed by reset.
  assign f_rvalid = rd_vld_q && !rst;
  assign f_err    = rd_vld_q && rd_err_q && !rst;
  assign f_rdata  = (f_rvalid && !rd_err_q) ? mem_data_out : '0;
  assign cpu_hold = rst || (state_q == BOOT);
  assign load_err = load_err_q && !rst;

endmodule
